// File: rtl/cmos_dvp_transmit_if.sv
// DVP byte stream plus the show-ahead pixel request/response pair of the camera transmitter.
interface cmos_dvp_transmit_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [15:0] pix_data;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;

  modport master (
    output pix_req, pix_x, pix_y, cam_vsync, cam_href, cam_data,
    input  pix_data
  );

  modport slave (
    input  pix_req, pix_x, pix_y, cam_vsync, cam_href, cam_data,
    output pix_data
  );
endinterface

// File: rtl/cmos_dvp_transmit.sv
// DVP camera transmitter: emits an RGB565 frame high byte first, from an external
// show-ahead source or a built-in test pattern. LINE_CYC must stay below 4096.
module cmos_dvp_transmit #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned VS_LINES = 2,
  parameter int unsigned VB_LINES = 8,
  parameter int unsigned VF_LINES = 4
) (
  input  logic                   cam_pclk,
  input  logic                   rst_n,
  input  logic                   tx_en,
  input  logic [1:0]             pattern_sel,
  cmos_dvp_transmit_if.master    dvp,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt
);

  localparam int unsigned LINE_CYC = 2 * H_ACTIVE + H_BLANK;

  localparam logic [11:0] LineLast = 12'(LINE_CYC - 1);
  localparam logic [11:0] HrefEnd  = 12'(2 * H_ACTIVE);
  localparam logic [11:0] HrefLast = 12'(2 * H_ACTIVE - 1);
  localparam logic [11:0] VsLast   = 12'(VS_LINES - 1);
  localparam logic [11:0] VbLast   = 12'(VB_LINES - 1);
  localparam logic [11:0] VaLast   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VfLast   = 12'(VF_LINES - 1);
  localparam logic [11:0] BarW     = 12'(H_ACTIVE / 8);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e      state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  low_q, low_d;

  logic        line_end;
  logic        pix_req;
  logic [11:0] pix_x, pix_y;
  logic [11:0] bar;
  logic [15:0] bar_col;
  logic [15:0] pix_val;

  assign line_end = (h_cnt_q == LineLast);

  // Frame sequencing: every non-idle state is counted in whole lines.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = line_end ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d     = line_end ? v_cnt_q + 12'd1 : v_cnt_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;
    frame_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
        if (tx_en) state_d = StVsync;
      end
      StVsync: begin
        if (line_end && v_cnt_q == VsLast) begin
          state_d = StVback;
          v_cnt_d = 12'd0;
        end
      end
      StVback: begin
        if (line_end && v_cnt_q == VbLast) begin
          state_d = StActive;
          v_cnt_d = 12'd0;
        end
      end
      StActive: begin
        if (line_end && v_cnt_q == VaLast) begin
          state_d = StVfront;
          v_cnt_d = 12'd0;
        end
      end
      StVfront: begin
        if (line_end && v_cnt_q == VfLast) begin
          frame_done  = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          v_cnt_d     = 12'd0;
          state_d     = tx_en ? StVsync : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StVsync && state_q != StVsync) pat_d = pattern_sel;
  end

  // A request precedes each high-byte cycle; the first of a line sits on the previous line end.
  always_comb begin
    pix_req = 1'b0;
    pix_x   = 12'd0;
    pix_y   = 12'd0;
    if (state_q == StActive && h_cnt_q[0] && h_cnt_q < HrefLast) begin
      pix_req = 1'b1;
      pix_x   = (h_cnt_q + 12'd1) >> 1;
      pix_y   = v_cnt_q;
    end else if (line_end && ((state_q == StVback && v_cnt_q == VbLast) ||
                              (state_q == StActive && v_cnt_q != VaLast))) begin
      pix_req = 1'b1;
      pix_y   = (state_q == StActive) ? v_cnt_q + 12'd1 : 12'd0;
    end
  end

  assign bar = pix_x / BarW;

  always_comb begin
    bar_col = 16'h0000;
    if (bar > 12'd7) begin
      bar_col = 16'h0000;
    end else begin
      unique case (bar[2:0])
        3'd0: bar_col = 16'hFFFF;
        3'd1: bar_col = 16'hFFE0;
        3'd2: bar_col = 16'h07FF;
        3'd3: bar_col = 16'h07E0;
        3'd4: bar_col = 16'hF81F;
        3'd5: bar_col = 16'hF800;
        3'd6: bar_col = 16'h001F;
        3'd7: bar_col = 16'h0000;
        default: bar_col = 16'h0000;
      endcase
    end
  end

  always_comb begin
    pix_val = 16'hFFFF;
    unique case (pat_q)
      2'd0: pix_val = dvp.pix_data;
      2'd1: pix_val = bar_col;
      2'd2: pix_val = {pix_x[4:0], pix_y[5:0], frame_cnt_q[4:0]};
      2'd3: pix_val = 16'hFFFF;
      default: pix_val = 16'hFFFF;
    endcase
  end

  // Stream outputs are registered from next-state values so they line up with the counters.
  always_comb begin
    vsync_d = (state_d == StVsync);
    href_d  = (state_d == StActive) && (h_cnt_d < HrefEnd);
    low_d   = pix_req ? pix_val[7:0] : low_q;
    if (pix_req)     data_d = pix_val[15:8];
    else if (href_d) data_d = low_q;
    else             data_d = 8'h00;
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      h_cnt_q     <= 12'd0;
      v_cnt_q     <= 12'd0;
      pat_q       <= 2'd0;
      frame_cnt_q <= 8'd0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      low_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      low_q       <= low_d;
    end
  end

  assign dvp.pix_req   = pix_req;
  assign dvp.pix_x     = pix_x;
  assign dvp.pix_y     = pix_y;
  assign dvp.cam_vsync = vsync_q;
  assign dvp.cam_href  = href_q;
  assign dvp.cam_data  = data_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
